// File: rtl/clock_div_bank.sv
// clock_div_bank: a bank of NUM_CH independent integer clock dividers
// running from one source clock. Each channel has a runtime-programmable
// ratio and its own enable, and all channels can be restarted in phase
// together. A ratio change waits for a period boundary, so the divided
// clock never produces a runt pulse. Every output comes straight from a
// flop. A shared counter counts rising edges on one selected channel.
module clock_div_bank #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int CNT_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync_all,
    input  logic [CH_W-1:0]   mon_sel,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] strobe,
    output logic [CNT_W-1:0]  toggle_counter
);

    // Per-channel state
    logic [DIV_W-1:0]  r_div_act  [NUM_CH];
    logic [DIV_W-1:0]  r_div_pend [NUM_CH];
    logic [DIV_W-1:0]  r_cnt      [NUM_CH];
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_strobe;
    logic [CNT_W-1:0]  r_toggle_cnt;

    // Next-state helpers
    logic [DIV_W-1:0]  w_cnt_next [NUM_CH];
    logic [DIV_W-1:0]  w_div_next [NUM_CH];
    logic [DIV_W-1:0]  w_half     [NUM_CH];
    logic [NUM_CH-1:0] w_cfg_hit;
    logic [DIV_W-1:0]  w_cfg_div_clamped;
    logic              w_mon_hit;

    assign clk_out        = r_clk_out;
    assign strobe         = r_strobe;
    assign toggle_counter = r_toggle_cnt;

    // Ratios 0 and 1 cannot make a clock, so they are captured as 2
    assign w_cfg_div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

    // Phase counter advance; the pending ratio takes over only on a wrap
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cnt[i] == (r_div_act[i] - DIV_W'(1))) begin
                w_cnt_next[i] = '0;
                w_div_next[i] = r_div_pend[i];
            end else begin
                w_cnt_next[i] = r_cnt[i] + DIV_W'(1);
                w_div_next[i] = r_div_act[i];
            end
            w_half[i] = w_div_next[i] >> 1;
        end
    end

    // Decode the config write target; out-of-range channels match nothing
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    // Select the monitored strobe; out-of-range selects fall back to channel 0
    always_comb begin
        w_mon_hit = r_strobe[0];
        for (int i = 1; i < NUM_CH; i++) begin
            w_mon_hit = (mon_sel == CH_W'(i)) ? r_strobe[i] : w_mon_hit;
        end
    end

    // Divider channels: config capture, counting, phase sync and outputs
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                r_div_act[i]  <= DIV_W'(2);
                r_div_pend[i] <= DIV_W'(2);
                r_cnt[i]      <= '0;
                r_clk_out[i]  <= 1'b0;
                r_strobe[i]   <= 1'b0;
            end else begin
                if (w_cfg_hit[i]) begin
                    r_div_pend[i] <= w_cfg_div_clamped;
                end else begin
                    r_div_pend[i] <= r_div_pend[i];
                end
                if (!ch_en[i] || sync_all) begin
                    // Idle or restarting: hold phase zero, adopt ratio now
                    r_cnt[i]     <= '0;
                    r_div_act[i] <= r_div_pend[i];
                    r_clk_out[i] <= 1'b0;
                    r_strobe[i]  <= 1'b0;
                end else begin
                    r_cnt[i]     <= w_cnt_next[i];
                    r_div_act[i] <= w_div_next[i];
                    r_clk_out[i] <= (w_cnt_next[i] >= w_half[i]);
                    r_strobe[i]  <= (w_cnt_next[i] == w_half[i]);
                end
            end
        end
    end

    // Rising-edge monitor, one cycle behind the selected strobe
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_toggle_cnt <= '0;
        end else if (w_mon_hit) begin
            r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
        end else begin
            r_toggle_cnt <= r_toggle_cnt;
        end
    end

endmodule

// File: tb/tb_clock_div_bank.sv
// Bench for clock_div_bank. Two instances share stimulus: a 4-channel bank
// with an 8-bit monitor, and a 3-channel bank with a 3-bit monitor where
// cfg_ch=3 is out of range. A behavioural model predicts the outputs of
// every edge into a scoreboard queue; directed tests add hand-derived values.
module tb_clock_div_bank;

    logic       clk;
    logic       rst;
    logic [3:0] ch_en;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       sync_all;
    logic [1:0] mon_sel;

    logic [3:0] a_clk, a_stb;
    logic [7:0] a_tog;
    logic [2:0] b_clk, b_stb;
    logic [2:0] b_tog;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [3:0] aco;
        logic [3:0] ast;
        logic [7:0] atog;
        logic [2:0] bco;
        logic [2:0] bst;
        logic [2:0] btog;
    } exp_t;

    exp_t sb_q[$];

    // Model state: index 0 is the 4-channel bank, index 1 the 3-channel bank
    int         m_act  [2][4];
    int         m_pend [2][4];
    int         m_cnt  [2][4];
    logic [3:0] m_co   [2];
    logic [3:0] m_st   [2];
    int         m_tog  [2];

    clock_div_bank #(.NUM_CH(4), .DIV_W(8), .CNT_W(8)) u_dut_a (
        .clk_in         (clk),
        .rst            (rst),
        .ch_en          (ch_en),
        .cfg_we         (cfg_we),
        .cfg_ch         (cfg_ch),
        .cfg_div        (cfg_div),
        .sync_all       (sync_all),
        .mon_sel        (mon_sel),
        .clk_out        (a_clk),
        .strobe         (a_stb),
        .toggle_counter (a_tog)
    );

    clock_div_bank #(.NUM_CH(3), .DIV_W(8), .CNT_W(3)) u_dut_b (
        .clk_in         (clk),
        .rst            (rst),
        .ch_en          (ch_en[2:0]),
        .cfg_we         (cfg_we),
        .cfg_ch         (cfg_ch),
        .cfg_div        (cfg_div),
        .sync_all       (sync_all),
        .mon_sel        (mon_sel),
        .clk_out        (b_clk),
        .strobe         (b_stb),
        .toggle_counter (b_tog)
    );

    // Source clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one source edge using the inputs currently driven
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   nch;
            int   modv;
            int   sel;
            logic hit;
            nch  = (k == 0) ? 4 : 3;
            modv = (k == 0) ? 256 : 8;
            sel  = (int'(mon_sel) < nch) ? int'(mon_sel) : 0;
            hit  = m_st[k][sel];
            if (rst) m_tog[k] = 0;
            else if (hit) m_tog[k] = (m_tog[k] + 1) % modv;
            for (int i = 0; i < nch; i++) begin
                int old_pend;
                int nxt;
                old_pend = m_pend[k][i];
                if (rst) begin
                    m_act[k][i]  = 2;
                    m_pend[k][i] = 2;
                    m_cnt[k][i]  = 0;
                    m_co[k][i]   = 1'b0;
                    m_st[k][i]   = 1'b0;
                end else begin
                    if (cfg_we && int'(cfg_ch) == i)
                        m_pend[k][i] = (cfg_div < 8'd2) ? 2 : int'(cfg_div);
                    if (!ch_en[i] || sync_all) begin
                        m_cnt[k][i] = 0;
                        m_act[k][i] = old_pend;
                        m_co[k][i]  = 1'b0;
                        m_st[k][i]  = 1'b0;
                    end else begin
                        nxt = m_cnt[k][i] + 1;
                        if (nxt == m_act[k][i]) begin
                            nxt = 0;
                            m_act[k][i] = old_pend;
                        end
                        m_cnt[k][i] = nxt;
                        m_co[k][i]  = (nxt >= m_act[k][i] / 2);
                        m_st[k][i]  = (nxt == m_act[k][i] / 2);
                    end
                end
            end
        end
    endtask

    // One source edge: predict, push, clock, then pop and compare
    task automatic step();
        exp_t e;
        model_edge();
        e.aco  = m_co[0];
        e.ast  = m_st[0];
        e.atog = m_tog[0][7:0];
        e.bco  = m_co[1][2:0];
        e.bst  = m_st[1][2:0];
        e.btog = m_tog[1][2:0];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("a_clk_out", a_clk, e.aco);
        check("a_strobe",  a_stb, e.ast);
        check("a_toggle",  a_tog, e.atog);
        check("b_clk_out", b_clk, e.bco);
        check("b_strobe",  b_stb, e.bst);
        check("b_toggle",  b_tog, e.btog);
    endtask

    logic [9:0]  pat_c, pat_s;
    logic [11:0] pat12;
    logic [3:0]  pat4;
    int          rise [3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < 2; k++) begin
            m_co[k]  = '0;
            m_st[k]  = '0;
            m_tog[k] = 0;
            for (int i = 0; i < 4; i++) begin
                m_act[k][i]  = 2;
                m_pend[k][i] = 2;
                m_cnt[k][i]  = 0;
            end
        end
        clk = 1'b0; rst = 1'b1; ch_en = 4'hF; cfg_we = 1'b0; cfg_ch = 2'd0;
        cfg_div = 8'd0; sync_all = 1'b0; mon_sel = 2'd0;

        // Reset, then default ratio 2 on every channel for 20 edges
        step();
        check("rst_clk_out", a_clk, 0);
        check("rst_toggle",  a_tog, 0);
        rst = 1'b0;
        repeat (20) step();
        check("d2_toggle20_a", a_tog, 10);
        check("d2_toggle20_b", b_tog, 2);

        // D=5 written to disabled ch1, then enabled; monitor ch1 for 50 edges
        rst = 1'b1; ch_en = 4'b1101; mon_sel = 2'd1; step();
        rst = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; step();
        cfg_we = 1'b0; step();
        ch_en = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            pat_c[9-i] = a_clk[1];
            pat_s[9-i] = a_stb[1];
        end
        check("d5_clk_pattern",    pat_c, 10'b0111001110);
        check("d5_strobe_pattern", pat_s, 10'b0100001000);
        repeat (40) step();
        check("mon_wrap_b", b_tog, 2);
        check("mon_count_a", a_tog, 10);

        // Reset mid-period overrides enable, config write and sync
        repeat (2) step();
        rst = 1'b1; cfg_we = 1'b1; sync_all = 1'b1; step();
        check("midrst_clk_out", a_clk, 0);
        check("midrst_strobe",  a_stb, 0);
        check("midrst_toggle",  a_tog, 0);
        check("midrst_toggle_b", b_tog, 0);
        rst = 1'b0; cfg_we = 1'b0; sync_all = 1'b0; mon_sel = 2'd0;

        // Ch2 at D=4, write D=6 while cnt=1: old period completes first
        ch_en = 4'b1011;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4; step();
        cfg_we = 1'b0; step();
        ch_en = 4'hF;
        step(); pat12[11] = a_clk[2];
        cfg_we = 1'b1; cfg_div = 8'd6; step(); pat12[10] = a_clk[2];
        cfg_we = 1'b0;
        for (int i = 2; i < 12; i++) begin
            step();
            pat12[11-i] = a_clk[2];
        end
        check("d4_to_d6_pattern", pat12, 12'b0110_0011_1000);

        // Channels at D=3,4,7 then one sync_all pulse
        rst = 1'b1; step(); rst = 1'b0; ch_en = 4'h0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; step();
        cfg_ch = 2'd1; cfg_div = 8'd4; step();
        cfg_ch = 2'd2; cfg_div = 8'd7; step();
        cfg_we = 1'b0; step();
        ch_en = 4'hF;
        repeat (9) step();
        sync_all = 1'b1; step(); sync_all = 1'b0;
        check("sync_clk_out", a_clk, 0);
        check("sync_strobe",  a_stb, 0);
        for (int c = 0; c < 3; c++) rise[c] = 0;
        for (int e = 1; e <= 4; e++) begin
            step();
            for (int c = 0; c < 3; c++) begin
                if (rise[c] == 0 && a_clk[c]) rise[c] = e;
            end
        end
        check("sync_rise_d3", rise[0], 1);
        check("sync_rise_d4", rise[1], 2);
        check("sync_rise_d7", rise[2], 3);

        // cfg_div=0 clamps to 2; cfg_ch=3 is out of range for the 3-ch bank
        rst = 1'b1; step(); rst = 1'b0; ch_en = 4'b0111;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd5; step();
        cfg_div = 8'd0; step();
        cfg_we = 1'b0; step();
        ch_en = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            pat4[3-i] = a_clk[3];
        end
        check("clamp_d2_pattern", pat4, 4'b1010);

        // Random mix of enables, writes, syncs, monitor changes and resets
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 4; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_div  = 8'($urandom_range(0, 9));
            sync_all = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) mon_sel = 2'($urandom_range(0, 3));
            step();
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
